fighter_anim_ctrl: RTL and testbench
====================================

FIGHTER_ANIM_CTRL -- requirements
Module: fighter_anim_ctrl

Interface
REQ-001 SHALL have parameter FRAME_HOLD, default 4: frame_ticks per animation frame (legal 1..15).
REQ-002 SHALL have parameter WALK_FRAMES, default 4: walk cycle length (legal 2..4).
REQ-003 SHALL have parameter ATK_FRAMES, default 3: attack frames, startup/active/recovery (legal 3..4).
REQ-004 SHALL have parameter HIT_FRAMES, default 2: hitstun frames (legal 1..4).
REQ-005 SHALL have port vga_clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port frame_tick, input, 1: one-cycle pulse, once per video frame, at vertical-blank start.
REQ-008 SHALL have port walk_req, input, 1: level; the player is holding a direction.
REQ-009 SHALL have port atk_req, input, 1: one-cycle attack request pulse.
REQ-010 SHALL have port atk_kind, input, 1: 0 = punch, 1 = kick; sampled with atk_req.
REQ-011 SHALL have port hit_in, input, 1: one-cycle pulse; the player was struck.
REQ-012 SHALL have port anim_state, output, 2: STAND=0, WALK=1, ATTACK=2, HIT=3.
REQ-013 SHALL have port sprite_id, output, 3: STAND=0, WALK=1, PUNCH=2, KICK=3, HIT=4; selects the sprite ROM/palette pair.
REQ-014 SHALL have port frame_idx, output, 2: frame index within the current animation.
REQ-015 SHALL have port attack_active, output, 1: high iff anim_state==ATTACK and frame_idx==1 (hitbox live).
REQ-016 SHALL have port atk_ready, output, 1: high iff a request on atk_req this cycle would be latched.

Function
REQ-017 Outputs SHALL be registered; state, hold_cnt and frame_idx SHALL change only on cycles where frame_tick=1.
REQ-018 A latched request SHALL be acted on at the next frame_tick; a request on the same cycle as frame_tick SHALL be acted on at that tick.
REQ-019 atk_req SHALL latch atk_pend and atk_kind only when atk_ready=1; otherwise the request is dropped, with no queueing.
REQ-020 atk_ready SHALL be (state STAND or WALK, or state ATTACK with frame_idx==ATK_FRAMES-1) and atk_pend==0; the first request wins.
REQ-021 hit_in SHALL always set hit_pend; a hit takes priority over everything else.
REQ-022 hold_cnt SHALL count frame_ticks 0..FRAME_HOLD-1; at FRAME_HOLD-1 the tick wraps it to 0 and advances frame_idx.
REQ-023 Every state entry, including re-entry, SHALL zero hold_cnt and frame_idx.
REQ-024 At each tick, priority SHALL be: hit_pend -> HIT; else atk_pend (STAND/WALK, or ATTACK end) -> ATTACK; else the rules below.
REQ-025 STAND SHALL go to WALK when walk_req=1.
REQ-026 WALK SHALL go to STAND when walk_req=0; otherwise frame_idx wraps WALK_FRAMES-1 -> 0.
REQ-027 ATTACK SHALL end when the last frame's hold expires, going to WALK if walk_req else STAND, unless atk_pend is set.
REQ-028 ATTACK SHALL NOT be interrupted by walk_req or by a change of atk_kind.
REQ-029 HIT SHALL last HIT_FRAMES frames, then go to STAND or WALK per walk_req.
REQ-030 A hit during HIT SHALL restart hitstun.
REQ-031 Entering HIT SHALL clear atk_pend.
REQ-032 Consuming a pending request SHALL clear its pending flag on the same tick.
REQ-033 sprite_id SHALL be a function of state and the latched kind; the kind is held for the whole attack.

Reset
REQ-034 reset_n low SHALL immediately force: state STAND, sprite_id 0, frame_idx 0, hold_cnt 0, atk_pend 0, hit_pend 0, attack_active 0.
REQ-035 atk_ready SHALL read 1 while reset_n is low.
REQ-036 Reset asserted mid-attack SHALL abort the attack; no pending request survives reset.

Structure
REQ-037 The state enum, sprite_id encodings and atk_kind codes SHALL live in shared package fighter_pkg, also used by the sprite mux and hitbox logic.
REQ-038 The hold counter plus frame counter SHALL be one sub-module, anim_frame_counter: inputs clear and tick, output wrap.

Verification
REQ-039 Idle, walk_req=1 before tick 1 -> WALK at tick 1; frame_idx 1,2,3,0 at ticks 5,9,13,17.
REQ-040 atk_req with kind=1 in STAND, then 12 ticks -> sprite_id 3, attack_active high for ticks 5-8 only, STAND at tick 13.
REQ-041 atk_req while ATTACK frame_idx==0 -> dropped; atk_req in frame 2 -> new attack at the end tick, frame_idx 0.
REQ-042 hit_in during ATTACK frame 1 -> HIT at next tick, attack_active 0, atk_pend cleared, STAND 8 ticks later.
REQ-043 hit_in, atk_req and frame_tick on the same cycle from STAND -> HIT; a second hit_in at HIT tick 6 -> hitstun restarts.
REQ-044 reset_n pulsed low mid-attack without vga_clk edges -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared encodings for the fighter animation controller, sprite mux and hitbox logic.
package fighter_pkg;

  typedef enum logic [1:0] {
    ST_STAND  = 2'd0,
    ST_WALK   = 2'd1,
    ST_ATTACK = 2'd2,
    ST_HIT    = 2'd3
  } anim_state_e;

  typedef enum logic [2:0] {
    SPR_STAND = 3'd0,
    SPR_WALK  = 3'd1,
    SPR_PUNCH = 3'd2,
    SPR_KICK  = 3'd3,
    SPR_HIT   = 3'd4
  } sprite_e;

  typedef enum logic {
    KIND_PUNCH = 1'b0,
    KIND_KICK  = 1'b1
  } atk_kind_e;

  localparam int unsigned HOLD_W  = 4;
  localparam int unsigned FRAME_W = 2;

  function automatic sprite_e sprite_of(input anim_state_e st, input atk_kind_e kind);
    sprite_of = SPR_STAND;
    case (st)
      ST_STAND:  sprite_of = SPR_STAND;
      ST_WALK:   sprite_of = SPR_WALK;
      ST_ATTACK: sprite_of = (kind == KIND_KICK) ? SPR_KICK : SPR_PUNCH;
      ST_HIT:    sprite_of = SPR_HIT;
    endcase
  endfunction

endpackage

// File: rtl/fighter_anim_ctrl_if.sv
// Player-input and animation-status bundle between the game logic and the animation controller.
interface fighter_anim_ctrl_if;
  import fighter_pkg::*;

  logic                 frame_tick;
  logic                 walk_req;
  logic                 atk_req;
  atk_kind_e            atk_kind;
  logic                 hit_in;
  anim_state_e          anim_state;
  sprite_e              sprite_id;
  logic [FRAME_W-1:0]   frame_idx;
  logic                 attack_active;
  logic                 atk_ready;

  modport master (
    output frame_tick, walk_req, atk_req, atk_kind, hit_in,
    input  anim_state, sprite_id, frame_idx, attack_active, atk_ready
  );

  modport slave (
    input  frame_tick, walk_req, atk_req, atk_kind, hit_in,
    output anim_state, sprite_id, frame_idx, attack_active, atk_ready
  );
endinterface

// File: rtl/anim_frame_counter.sv
// Hold counter (frame_ticks per frame) cascaded into the frame index of the current animation.
module anim_frame_counter
  import fighter_pkg::*;
#(
  parameter int unsigned FRAME_HOLD = 4
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               clear,
  input  logic [FRAME_W-1:0] last_frame,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               wrap
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);

  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  // wrap marks the tick on which the current frame's hold expires
  assign wrap      = tick && (hold_q == HOLD_LAST);
  assign frame_idx = frame_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    hold_d  = hold_q;
    frame_d = frame_q;
    if (clear) begin
      hold_d  = '0;
      frame_d = '0;
    end else if (wrap) begin
      hold_d  = '0;
      frame_d = (frame_q == last_frame) ? '0 : frame_q + 1'b1;
    end else if (tick) begin
      hold_d  = hold_q + 1'b1;
    end
  end

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Fighter animation state machine: stand/walk/attack/hitstun driven by per-video-frame ticks.
module fighter_anim_ctrl
  import fighter_pkg::*;
#(
  parameter int unsigned FRAME_HOLD  = 4,
  parameter int unsigned WALK_FRAMES = 4,
  parameter int unsigned ATK_FRAMES  = 3,
  parameter int unsigned HIT_FRAMES  = 2
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  fighter_anim_ctrl_if.slave  bus
);

  localparam logic [FRAME_W-1:0] WALK_LAST = FRAME_W'(WALK_FRAMES - 1);
  localparam logic [FRAME_W-1:0] ATK_LAST  = FRAME_W'(ATK_FRAMES - 1);
  localparam logic [FRAME_W-1:0] HIT_LAST  = FRAME_W'(HIT_FRAMES - 1);

  anim_state_e        state_q, state_d;
  logic               atk_pend_q, atk_pend_d;
  atk_kind_e          pend_kind_q, pend_kind_d;
  atk_kind_e          cur_kind_q, cur_kind_d;
  logic               hit_pend_q, hit_pend_d;

  logic [FRAME_W-1:0] frame_idx;
  logic [FRAME_W-1:0] last_frame;
  logic               hold_wrap;
  logic               cnt_clear;

  logic               atk_ready, atk_take, atk_eff, hit_eff;
  atk_kind_e          kind_eff;
  logic               attack_end, hit_end, idle_state;

  anim_frame_counter #(
    .FRAME_HOLD (FRAME_HOLD)
  ) u_cnt (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .tick       (bus.frame_tick),
    .clear      (cnt_clear),
    .last_frame (last_frame),
    .frame_idx  (frame_idx),
    .wrap       (hold_wrap)
  );

  // A request arriving on the tick cycle itself is folded into the pending view
  assign idle_state = (state_q == ST_STAND) || (state_q == ST_WALK);
  assign atk_ready  = (idle_state || (state_q == ST_ATTACK && frame_idx == ATK_LAST)) && !atk_pend_q;
  assign atk_take   = bus.atk_req && atk_ready;
  assign atk_eff    = atk_pend_q || atk_take;
  assign kind_eff   = atk_take ? bus.atk_kind : pend_kind_q;
  assign hit_eff    = hit_pend_q || bus.hit_in;
  assign attack_end = (state_q == ST_ATTACK) && (frame_idx == ATK_LAST) && hold_wrap;
  assign hit_end    = (state_q == ST_HIT) && (frame_idx == HIT_LAST) && hold_wrap;

  always_comb begin
    last_frame = '0;
    case (state_q)
      ST_STAND:  last_frame = '0;
      ST_WALK:   last_frame = WALK_LAST;
      ST_ATTACK: last_frame = ATK_LAST;
      ST_HIT:    last_frame = HIT_LAST;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_STAND;
      atk_pend_q  <= 1'b0;
      pend_kind_q <= KIND_PUNCH;
      cur_kind_q  <= KIND_PUNCH;
      hit_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      atk_pend_q  <= atk_pend_d;
      pend_kind_q <= pend_kind_d;
      cur_kind_q  <= cur_kind_d;
      hit_pend_q  <= hit_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    atk_pend_d  = atk_eff;
    pend_kind_d = kind_eff;
    cur_kind_d  = cur_kind_q;
    hit_pend_d  = hit_eff;
    cnt_clear   = 1'b0;
    if (bus.frame_tick) begin
      hit_pend_d = 1'b0;
      if (hit_eff) begin
        state_d    = ST_HIT;
        atk_pend_d = 1'b0;
        cnt_clear  = 1'b1;
      end else if (atk_eff && (idle_state || attack_end)) begin
        state_d    = ST_ATTACK;
        cur_kind_d = kind_eff;
        atk_pend_d = 1'b0;
        cnt_clear  = 1'b1;
      end else begin
        case (state_q)
          ST_STAND: if (bus.walk_req) begin
            state_d   = ST_WALK;
            cnt_clear = 1'b1;
          end
          ST_WALK: if (!bus.walk_req) begin
            state_d   = ST_STAND;
            cnt_clear = 1'b1;
          end
          ST_ATTACK: if (attack_end) begin
            state_d   = bus.walk_req ? ST_WALK : ST_STAND;
            cnt_clear = 1'b1;
          end
          ST_HIT: if (hit_end) begin
            state_d   = bus.walk_req ? ST_WALK : ST_STAND;
            cnt_clear = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.anim_state    = state_q;
    bus.sprite_id     = sprite_of(state_q, cur_kind_q);
    bus.frame_idx     = frame_idx;
    bus.attack_active = (state_q == ST_ATTACK) && (frame_idx == FRAME_W'(1));
    bus.atk_ready     = atk_ready;
  end

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed checks of the fighter animation controller with default parameters.
module tb_fighter_anim_ctrl;
  import fighter_pkg::*;

  logic vga_clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 vga_clk = ~vga_clk;

  fighter_anim_ctrl_if bus ();

  fighter_anim_ctrl #(
    .FRAME_HOLD  (4),
    .WALK_FRAMES (4),
    .ATK_FRAMES  (3),
    .HIT_FRAMES  (2)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse(input logic tk, input logic ar, input logic hi);
    bus.frame_tick = tk;
    bus.atk_req    = ar;
    bus.hit_in     = hi;
    idle();
    bus.frame_tick = 1'b0;
    bus.atk_req    = 1'b0;
    bus.hit_in     = 1'b0;
    idle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_sf(input string tag, input logic [31:0] st, input logic [31:0] fr);
    chk({tag, ".state"}, 32'(bus.anim_state), st);
    chk({tag, ".frame"}, 32'(bus.frame_idx), fr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] walk_exp [4];
    walk_exp = '{32'd1, 32'd2, 32'd3, 32'd0};

    reset_n        = 1'b0;
    bus.frame_tick = 1'b0;
    bus.walk_req   = 1'b0;
    bus.atk_req    = 1'b0;
    bus.atk_kind   = KIND_PUNCH;
    bus.hit_in     = 1'b0;

    #3;
    chk_sf("rst", 0, 0);
    chk("rst.sprite", 32'(bus.sprite_id), 0);
    chk("rst.active", 32'(bus.attack_active), 0);
    chk("rst.ready", 32'(bus.atk_ready), 1);
    @(negedge vga_clk);
    reset_n = 1'b1;
    idle();

    // walk cycle
    bus.walk_req = 1'b1;
    idle();
    ticks(1);
    chk_sf("walk.t1", 1, 0);
    chk("walk.sprite", 32'(bus.sprite_id), 1);
    for (int i = 0; i < 4; i++) begin
      ticks(4);
      chk("walk.frame", 32'(bus.frame_idx), walk_exp[i]);
    end
    chk("walk.t17.state", 32'(bus.anim_state), 1);
    bus.walk_req = 1'b0;
    ticks(1);
    chk_sf("walk.stop", 0, 0);

    // kick from stand, 12 ticks of attack
    bus.atk_kind = KIND_KICK;
    pulse(1'b0, 1'b1, 1'b0);
    chk("kick.ready_pend", 32'(bus.atk_ready), 0);
    bus.atk_kind = KIND_PUNCH;
    ticks(1);
    chk_sf("kick.t1", 2, 0);
    chk("kick.sprite", 32'(bus.sprite_id), 3);
    chk("kick.t1.active", 32'(bus.attack_active), 0);
    for (int t = 2; t <= 13; t++) begin
      ticks(1);
      chk("kick.active", 32'(bus.attack_active), (t >= 5 && t <= 8) ? 32'd1 : 32'd0);
      if (t == 5) chk("kick.t5.sprite", 32'(bus.sprite_id), 3);
      if (t == 12) chk_sf("kick.t12", 2, 2);
    end
    chk_sf("kick.t13", 0, 0);
    chk("kick.t13.sprite", 32'(bus.sprite_id), 0);

    // drop in frame 0, chain in frame 2
    bus.atk_kind = KIND_PUNCH;
    pulse(1'b0, 1'b1, 1'b0);
    ticks(1);
    chk("chain.t1.sprite", 32'(bus.sprite_id), 2);
    bus.atk_kind = KIND_KICK;
    pulse(1'b0, 1'b1, 1'b0);
    chk("chain.drop.ready", 32'(bus.atk_ready), 0);
    ticks(8);
    chk_sf("chain.t9", 2, 2);
    chk("chain.t9.ready", 32'(bus.atk_ready), 1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("chain.latched.ready", 32'(bus.atk_ready), 0);
    chk("chain.latched.sprite", 32'(bus.sprite_id), 2);
    ticks(3);
    chk_sf("chain.t12", 2, 2);
    ticks(1);
    chk_sf("chain.t13", 2, 0);
    chk("chain.t13.sprite", 32'(bus.sprite_id), 3);
    chk("chain.t13.ready", 32'(bus.atk_ready), 0);
    bus.walk_req = 1'b1;
    ticks(1);
    chk("chain.walk_no_int", 32'(bus.anim_state), 2);
    ticks(10);
    chk_sf("chain.n12", 2, 2);
    ticks(1);
    chk_sf("chain.end_walk", 1, 0);
    bus.walk_req = 1'b0;
    ticks(1);
    chk("chain.stand", 32'(bus.anim_state), 0);

    // hit during active frame
    bus.atk_kind = KIND_PUNCH;
    pulse(1'b0, 1'b1, 1'b0);
    ticks(5);
    chk_sf("hitatk.t5", 2, 1);
    chk("hitatk.t5.active", 32'(bus.attack_active), 1);
    pulse(1'b0, 1'b0, 1'b1);
    ticks(1);
    chk_sf("hitatk.hit", 3, 0);
    chk("hitatk.sprite", 32'(bus.sprite_id), 4);
    chk("hitatk.active", 32'(bus.attack_active), 0);
    chk("hitatk.ready", 32'(bus.atk_ready), 0);
    ticks(7);
    chk_sf("hitatk.h7", 3, 1);
    ticks(1);
    chk_sf("hitatk.h8", 0, 0);

    // latched attack and hit before a tick: hit wins, attack discarded
    bus.atk_kind = KIND_KICK;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    ticks(1);
    chk("pend.hit", 32'(bus.anim_state), 3);
    ticks(8);
    chk("pend.stand", 32'(bus.anim_state), 0);
    ticks(1);
    chk("pend.no_atk", 32'(bus.anim_state), 0);
    chk("pend.ready", 32'(bus.atk_ready), 1);

    // hit, attack and tick together; hitstun restart on a later hit
    pulse(1'b1, 1'b1, 1'b1);
    chk_sf("same.hit", 3, 0);
    ticks(5);
    chk_sf("same.h5", 3, 1);
    pulse(1'b1, 1'b0, 1'b1);
    chk_sf("same.restart", 3, 0);
    ticks(7);
    chk_sf("same.r7", 3, 1);
    bus.walk_req = 1'b1;
    ticks(1);
    chk_sf("same.end_walk", 1, 0);
    bus.walk_req = 1'b0;
    ticks(1);
    chk("same.stand", 32'(bus.anim_state), 0);
    chk("same.ready", 32'(bus.atk_ready), 1);

    // asynchronous reset mid-attack with a hit pending
    pulse(1'b0, 1'b1, 1'b0);
    ticks(5);
    chk("arst.pre.active", 32'(bus.attack_active), 1);
    pulse(1'b0, 1'b0, 1'b1);
    #1;
    reset_n = 1'b0;
    #2;
    chk_sf("arst", 0, 0);
    chk("arst.sprite", 32'(bus.sprite_id), 0);
    chk("arst.active", 32'(bus.attack_active), 0);
    chk("arst.ready", 32'(bus.atk_ready), 1);
    @(negedge vga_clk);
    reset_n = 1'b1;
    idle();
    ticks(1);
    chk_sf("arst.after", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
